// File: rtl/data_mem_io_pkg.sv
// Shared constants for data_mem_io: I/O region base, register offsets and
// status-word bit positions.
package h2bp;

    localparam logic [3:0] IO_BASE   = 4'hF;
    localparam logic [1:0] IO_TXDATA = 2'd0;
    localparam logic [1:0] IO_STATUS = 2'd1;
    localparam logic [1:0] IO_CYCLES = 2'd2;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 8;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] w;
        w = '0;
        w[STATUS_COUNT_LSB +: 8] = count;
        w[STATUS_OVF]            = ovf;
        w[STATUS_FULL]           = full;
        w[STATUS_EMPTY]          = empty;
        return w;
    endfunction

endpackage

// File: rtl/data_mem_io_tx_fifo.sv
// Byte FIFO for the TX port. Push is accepted when not full, or when full
// with a same-cycle pop; head reads 0 while empty.
module tx_fifo #(
    parameter int TX_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [7:0]                push_data,
    input  logic                      pop,
    output logic [7:0]                head,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(TX_DEPTH):0] count
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(TX_DEPTH);

    logic [7:0]    mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign head    = empty ? 8'h00 : mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are PW bits wide so they wrap modulo TX_DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW + 1)'(1);
                2'b01:   cnt <= cnt - (PW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_io.sv
// Data-memory responder: word RAM plus memory-mapped TX FIFO, status and
// cycle counter. Counter present only with DATA_MEM_CYCLE_COUNTER_EN defined.
module data_mem_io
    import h2bp::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fault
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [31:0]   mem [RAM_DEPTH];
    logic [AW-1:0] ram_idx;
    logic          is_ram;
    logic          is_io;
    logic [1:0]    io_off;
    logic          io_wr;
    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic [7:0]    count8;
    logic [31:0]   io_rdata;
    logic [31:0]   cycles;

    logic [31:0]   ram_q;
    logic [31:0]   io_q;
    logic          sel_ram_q;
    logic          fault_q;
    logic          ovf_q;

    assign ram_idx = addr[AW-1:0];
    assign is_ram  = (addr[31:AW] == '0);
    assign is_io   = (addr[31:28] == IO_BASE);
    assign io_off  = addr[1:0];
    assign io_wr   = write && is_io && !rst;

    // tx_valid/tx_ready: one byte transfers at each posedge where both are
    // high; tx_data holds the head byte and stays stable until it transfers.
    assign push = io_wr && (io_off == IO_TXDATA);
    assign pop  = tx_valid && tx_ready && !rst;

    tx_fifo #(
        .TX_DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(data_i[7:0]),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    assign tx_valid = !empty;
    assign tx_data  = head;
    assign count8   = 8'(count);

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;

    // A write loads zero as this cycle's value, so the usual increment
    // still applies and the following cycle reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (io_wr && (io_off == IO_CYCLES)) begin
            cyc_q <= 32'd1;
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cycles = cyc_q;
`else
    assign cycles = '0;
`endif

    always_comb begin
        io_rdata = '0;
        if (is_io) begin
            case (io_off)
                IO_STATUS: io_rdata = status_word(count8, ovf_q, full, empty);
                IO_CYCLES: io_rdata = cycles;
                default:   io_rdata = '0;
            endcase
        end
    end

    // RAM kept free of reset so it maps onto block memory; write-first read.
    always_ff @(posedge clk) begin
        if (write && is_ram && !rst) begin
            mem[ram_idx] <= data_i;
        end
        ram_q <= write ? data_i : mem[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_ram_q <= 1'b0;
            io_q      <= '0;
            fault_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sel_ram_q <= is_ram;
            io_q      <= io_rdata;
            fault_q   <= !is_ram && !is_io;
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (io_wr && (io_off == IO_STATUS) && data_i[STATUS_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign data_o = sel_ram_q ? ram_q : io_q;
    assign fault  = fault_q;

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- Responder end of the core's data-memory interface.
- Every cycle it accepts a word address, a write strobe and write data from the function stage; for reads it returns data one cycle later, in the data stage.
- Contains a word-addressed RAM and a small memory-mapped I/O region: a TX byte FIFO drained by a ready/valid consumer, and a free-running cycle counter.
- Replaces the plain data memory behind the same addr/write/data_i/data_o interface.

Parameters:
- RAM_DEPTH, 1024, number of 32-bit RAM words; must be a power of two.
- TX_DEPTH, 8, TX FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr  in  32  word address, valid every cycle
- write  in  1  store strobe; store commits at the posedge where write=1
- data_i  in  32  store data
- data_o  out  32  load data for the address presented on the previous cycle
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts head byte when tx_valid && tx_ready
- fault  out  1  one-cycle pulse: the previous cycle's access was unmapped

Behaviour:
- Reset uses only clk and rst, synchronous, active-high. Fixed.
- Reset values:
  - data_o=0, tx_valid=0, tx_data=0, fault=0.
  - FIFO empty, overflow flag 0, cycle counter 0.
  - RAM contents are not cleared.
- Address decode:
  - addr < RAM_DEPTH: RAM.
  - addr[31:28]==4'hF: I/O, decoded on addr[1:0].
  - Anything else: unmapped.
- Read latency is exactly 1 cycle. data_o is registered from every address presented, regardless of write.
- RAM read-during-write to the same address is write-first: data_o gets data_i.
- RAM write: mem[addr] <= data_i at the posedge with write=1.
- I/O map:
  - IO_TXDATA (F000_0000): write pushes data_i[7:0] into the FIFO; read returns 0.
  - IO_STATUS (F000_0001): read returns {16'b0, count[7:0], 5'b0, overflow, full, empty}. count is zero-extended. Write with data_i[2]=1 clears overflow.
  - IO_CYCLES (F000_0002): read returns counter value before this cycle's increment. Write loads counter with 0.
  - F000_0003: reads 0, writes ignored, no fault.
- Cycle counter: 32-bit, +1 every cycle, wraps FFFF_FFFF -> 0.
- FIFO rules:
  - push accepted when !full, or when full and a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow sets (sticky).
  - Pop on tx_valid && tx_ready.
  - Push into an empty FIFO makes tx_valid=1 the next cycle. There is no bypass.
  - Pointers wrap modulo TX_DEPTH.
  - count ranges 0..TX_DEPTH.
- Status reflects state before same-cycle push/pop.
- Unmapped access:
  - write ignored.
  - next cycle data_o=0 and fault=1 for one cycle.
- rst has priority over every same-cycle write, push or pop. Anything in flight is discarded.

Optional Feature:
- Macro: DATA_MEM_CYCLE_COUNTER_EN.
- Defined: counter present as above.
- Undefined:
  - No counter register.
  - IO_CYCLES reads 0; writes to it are ignored with no fault.
  - All other behaviour is identical.

Decomposition:
- Package h2bp holds:
  - IO_BASE (4'hF), IO_TXDATA, IO_STATUS, IO_CYCLES offsets.
  - Status bit positions: STATUS_EMPTY=0, STATUS_FULL=1, STATUS_OVF=2, STATUS_COUNT_LSB=8.
- Sub-module tx_fifo(clk, rst, push, push_data, pop, head, empty, full, count), parameterised by TX_DEPTH.
- The RAM array, decode, counter and read mux live in data_mem_io.

Test Plan:
- Write 0x1234_5678 @5, then read @5 next cycle -> data_o=0x1234_5678 one cycle after the read address.
- Write 0xAAAA_0001 @7 with addr=7 held -> data_o=0xAAAA_0001 the following cycle (write-first).
- tx_ready=0; 9 writes to F000_0000 with 0x41..0x49 -> status read = 0x0000_0806 (count 8, full, overflow). Then tx_ready=1 -> bytes 0x41..0x48 out in order; 0x49 never appears.
- FIFO full, push 0x50 while popping the same cycle -> push accepted; count stays 8; overflow stays 0.
- Read F000_0002 at cycles N and N+10 -> difference 10. Write F000_0002 -> next read returns 1. With the macro undefined -> reads 0.
- Write to 0x0001_0000 -> RAM unchanged; fault=1 for exactly one cycle. Read of 0x0000_5000 -> data_o=0, fault pulse. Assert rst mid-FIFO-drain -> tx_valid=0 next cycle.
